// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller.
// Redirect source encoding, serializer FSM states and a counter width helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RS_NONE   = 2'd0,
    RS_BRANCH = 2'd1,
    RS_TRAP   = 2'd2,
    RS_SERIAL = 2'd3
  } redirect_sel_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_COMMIT = 2'd3
  } pipe_ctrl_state_t;

  function automatic int cnt_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline controller: stall/flush/redirect generation,
// hazard priority and CSR/fence serialization.
// Ports: clk, reset (sync, active-high); busy inputs (ibus/dbus/ex);
// hazard events (load_use, br_mispred_e, trap_m, serial_d);
// stage valids (valid_e/m/w); outputs all_ready, stall_*, flush_*,
// redirect_valid, redirect_sel.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int SERIAL_DEPTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ibus_busy,
  input  logic       dbus_busy,
  input  logic       ex_busy,
  input  logic       load_use,
  input  logic       br_mispred_e,
  input  logic       trap_m,
  input  logic       serial_d,
  input  logic       valid_e,
  input  logic       valid_m,
  input  logic       valid_w,
  output logic       all_ready,
  output logic       stall_pc,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_m,
  output logic       flush_w,
  output logic       redirect_valid,
  output logic [1:0] redirect_sel
);

  localparam int CW = cnt_width(SERIAL_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(SERIAL_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  pipe_ctrl_state_t r_state;
  pipe_ctrl_state_t w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  redirect_sel_t    w_sel;
  logic             w_empty;
  logic             w_hold;
  logic             w_issue;

  assign all_ready = ~(ibus_busy | dbus_busy | ex_busy);
  assign w_empty   = ~(valid_e | valid_m | valid_w);

  assign stall_e = 1'b0;
  assign stall_m = 1'b0;
  assign flush_w = 1'b0;

  assign redirect_valid = (w_sel != RS_NONE);
  assign redirect_sel   = w_sel;

  always_comb begin
    stall_pc    = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    w_sel       = RS_NONE;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold      = 1'b0;
    w_issue     = 1'b0;
    if (all_ready && !reset) begin
      if (trap_m) begin
        flush_d     = 1'b1;
        flush_e     = 1'b1;
        flush_m     = 1'b1;
        w_sel       = RS_TRAP;
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end else if (br_mispred_e) begin
        flush_d     = 1'b1;
        flush_e     = 1'b1;
        w_sel       = RS_BRANCH;
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end else begin
        unique case (r_state)
          ST_RUN: begin
            if (serial_d) begin
              if (w_empty) begin
                w_issue = 1'b1;
              end else begin
                w_hold      = 1'b1;
                w_state_nxt = ST_DRAIN;
              end
            end else if (load_use) begin
              w_hold = 1'b1;
            end
          end
          // An empty pipe releases in the same cycle so the
          // cost is exactly the occupied stages plus the tail.
          ST_DRAIN: begin
            if (w_empty) w_issue = 1'b1;
            else         w_hold  = 1'b1;
          end
          ST_ISSUE: w_issue = 1'b1;
          ST_COMMIT: begin
            stall_pc = 1'b1;
            flush_d  = 1'b1;
            if (r_cnt == CNT_MAX) begin
              w_sel       = RS_SERIAL;
              w_state_nxt = ST_RUN;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end
          default: w_state_nxt = ST_RUN;
        endcase
        if (w_hold) begin
          stall_pc = 1'b1;
          stall_d  = 1'b1;
          flush_e  = 1'b1;
        end
        // Release D->E while the fetch side is held and
        // anything younger is squashed.
        if (w_issue) begin
          stall_pc    = 1'b1;
          flush_d     = 1'b1;
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = ST_COMMIT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else if (all_ready) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl.
// Directed scenarios plus randomized traffic against a phase-level model.
module tb_pipe_ctrl;

  localparam int DEPTH = 3;

  localparam logic [9:0] IB = 10'b10_0000_0000;
  localparam logic [9:0] DB = 10'b01_0000_0000;
  localparam logic [9:0] EX = 10'b00_1000_0000;
  localparam logic [9:0] LU = 10'b00_0100_0000;
  localparam logic [9:0] BR = 10'b00_0010_0000;
  localparam logic [9:0] TR = 10'b00_0001_0000;
  localparam logic [9:0] SD = 10'b00_0000_1000;
  localparam logic [9:0] VE = 10'b00_0000_0100;
  localparam logic [9:0] VM = 10'b00_0000_0010;
  localparam logic [9:0] VW = 10'b00_0000_0001;

  // {all_ready,stall_pc,stall_d,stall_e,stall_m,
  //  flush_d,flush_e,flush_m,flush_w,redirect_valid,redirect_sel}
  localparam logic [11:0] O_IDLE  = 12'b1000_0000_0000;
  localparam logic [11:0] O_LU    = 12'b1110_0010_0000;
  localparam logic [11:0] O_BR    = 12'b1000_0110_0101;
  localparam logic [11:0] O_TRAP  = 12'b1000_0111_0110;
  localparam logic [11:0] O_BUSY  = 12'b0000_0000_0000;

  logic clk = 1'b0;
  logic reset;
  logic ibus_busy, dbus_busy, ex_busy;
  logic load_use, br_mispred_e, trap_m, serial_d;
  logic valid_e, valid_m, valid_w;
  logic all_ready, stall_pc, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic redirect_valid;
  logic [1:0] redirect_sel;

  always #5 clk = ~clk;

  pipe_ctrl #(.SERIAL_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .ibus_busy(ibus_busy), .dbus_busy(dbus_busy), .ex_busy(ex_busy),
    .load_use(load_use), .br_mispred_e(br_mispred_e),
    .trap_m(trap_m), .serial_d(serial_d),
    .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
    .all_ready(all_ready), .stall_pc(stall_pc), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .flush_w(flush_w), .redirect_valid(redirect_valid),
    .redirect_sel(redirect_sel)
  );

  wire [11:0] obs = {all_ready, stall_pc, stall_d, stall_e, stall_m,
                     flush_d, flush_e, flush_m, flush_w,
                     redirect_valid, redirect_sel};

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = no serializing instr pending,
  // 1 = it waits in D for older work to leave,
  // 2 = it has been released; age = ready cycles since release.
  int m_phase = 0, m_age = 0;
  int n_phase, n_age;
  logic [11:0] exp_v;

  task automatic drive(input logic [9:0] v);
    {ibus_busy, dbus_busy, ex_busy, load_use, br_mispred_e,
     trap_m, serial_d, valid_e, valid_m, valid_w} = v;
  endtask

  task automatic model_eval();
    logic rdy, empty, spc, sd, fd, fe, fm, rv;
    logic [1:0] rs;
    int k;
    rdy = !(ibus_busy || dbus_busy || ex_busy);
    empty = !(valid_e || valid_m || valid_w);
    {spc, sd, fd, fe, fm, rv} = '0;
    rs = 2'd0;
    n_phase = m_phase;
    n_age = m_age;
    if (reset) begin
      n_phase = 0;
      n_age = 0;
    end else if (rdy) begin
      if (trap_m) begin
        {fd, fe, fm, rv} = 4'b1111;
        rs = 2'd2;
        n_phase = 0;
        n_age = 0;
      end else if (br_mispred_e) begin
        {fd, fe, rv} = 3'b111;
        rs = 2'd1;
        n_phase = 0;
        n_age = 0;
      end else if (m_phase == 2) begin
        spc = 1'b1;
        fd = 1'b1;
        k = m_age + 1;
        if (k == DEPTH) begin
          rv = 1'b1;
          rs = 2'd3;
          n_phase = 0;
          n_age = 0;
        end else begin
          n_age = k;
        end
      end else if (m_phase == 1 || serial_d) begin
        if (empty) begin
          spc = 1'b1;
          fd = 1'b1;
          n_phase = 2;
          n_age = 0;
        end else begin
          {spc, sd, fe} = 3'b111;
          n_phase = 1;
        end
      end else if (load_use) begin
        {spc, sd, fe} = 3'b111;
      end
    end
    exp_v = {rdy, spc, sd, 1'b0, 1'b0, fd, fe, fm, 1'b0, rv, rs};
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    m_phase = n_phase;
    m_age = n_age;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(LU | SD | VE);
    sample();
    checks++;
    if (obs !== O_IDLE) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, O_IDLE);
    end
    advance();
    drive(DB);
    sample();
    checks++;
    if (obs !== O_BUSY) begin
      errors++;
      $display("FAIL reset_busy: got %b expected %b", obs, O_BUSY);
    end
    advance();
    reset = 1'b0;
    drive('0);
    sample();
    checks++;
    if (obs !== O_IDLE || obs !== exp_v) begin
      errors++;
      $display("FAIL after_reset: got %b expected %b", obs, O_IDLE);
    end
    advance();
  endtask

  task automatic test_load_use();
    drive(LU);
    sample();
    checks++;
    if (obs !== O_LU || obs !== exp_v) begin
      errors++;
      $display("FAIL load_use: got %b expected %b", obs, O_LU);
    end
    advance();
    drive('0);
    sample();
    checks++;
    if (obs !== O_IDLE) begin
      errors++;
      $display("FAIL load_use_after: got %b expected %b", obs, O_IDLE);
    end
    advance();
  endtask

  task automatic test_lu_branch();
    drive(LU | BR | VE);
    sample();
    checks++;
    if (obs !== O_BR || obs !== exp_v) begin
      errors++;
      $display("FAIL lu_branch: got %b expected %b", obs, O_BR);
    end
    advance();
  endtask

  task automatic test_serial_drain();
    logic [9:0] seq [7];
    int spc_cnt;
    seq[0] = SD | VE | VM | VW;
    seq[1] = SD | VM | VW;
    seq[2] = SD | VW;
    seq[3] = SD;
    seq[4] = VE;
    seq[5] = VM;
    seq[6] = VW;
    spc_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      drive(seq[c]);
      sample();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL serial_drain cyc%0d: got %b expected %b",
                 c, obs, exp_v);
      end
      if (stall_pc) spc_cnt++;
      if (c < 6) begin
        checks++;
        if (redirect_valid !== 1'b0) begin
          errors++;
          $display("FAIL serial_early_redirect cyc%0d: got %b expected 0",
                   c, redirect_valid);
        end
      end else begin
        checks++;
        if ({redirect_valid, redirect_sel} !== 3'b111) begin
          errors++;
          $display("FAIL serial_redirect: got %b expected 111",
                   {redirect_valid, redirect_sel});
        end
      end
      advance();
    end
    checks++;
    if (spc_cnt != 3 + DEPTH + 1) begin
      errors++;
      $display("FAIL serial_cost: got %0d expected %0d",
               spc_cnt, 3 + DEPTH + 1);
    end
    drive('0);
    sample();
    checks++;
    if (obs !== O_IDLE) begin
      errors++;
      $display("FAIL serial_back_to_run: got %b expected %b", obs, O_IDLE);
    end
    advance();
  endtask

  task automatic test_busy_commit();
    drive(SD);
    sample();
    advance();
    drive(VE);
    sample();
    advance();
    drive(VM);
    sample();
    advance();
    for (int c = 0; c < 4; c++) begin
      drive(VW | DB);
      sample();
      checks++;
      if (obs !== O_BUSY || obs !== exp_v) begin
        errors++;
        $display("FAIL busy_commit cyc%0d: got %b expected %b",
                 c, obs, O_BUSY);
      end
      advance();
    end
    drive(VW);
    sample();
    checks++;
    if ({redirect_valid, redirect_sel} !== 3'b111 || obs !== exp_v) begin
      errors++;
      $display("FAIL busy_commit_redirect: got %b expected %b",
               obs, exp_v);
    end
    advance();
  endtask

  task automatic test_trap_drain();
    drive(SD | VE);
    sample();
    advance();
    drive(SD | VM);
    sample();
    checks++;
    if (obs !== O_LU) begin
      errors++;
      $display("FAIL drain_hold: got %b expected %b", obs, O_LU);
    end
    advance();
    drive(SD | VW | TR);
    sample();
    checks++;
    if (obs !== O_TRAP || obs !== exp_v) begin
      errors++;
      $display("FAIL trap_drain: got %b expected %b", obs, O_TRAP);
    end
    advance();
    drive(LU);
    sample();
    checks++;
    if (obs !== O_LU) begin
      errors++;
      $display("FAIL trap_to_run: got %b expected %b", obs, O_LU);
    end
    advance();
  endtask

  task automatic test_branch_commit();
    drive(SD);
    sample();
    advance();
    drive(VE);
    sample();
    advance();
    drive(VM | BR);
    sample();
    checks++;
    if (obs !== O_BR) begin
      errors++;
      $display("FAIL branch_commit: got %b expected %b", obs, O_BR);
    end
    advance();
    drive(LU);
    sample();
    checks++;
    if (obs !== O_LU) begin
      errors++;
      $display("FAIL branch_to_run: got %b expected %b", obs, O_LU);
    end
    advance();
  endtask

  task automatic test_reset_commit();
    drive(SD);
    sample();
    advance();
    drive(VE);
    sample();
    advance();
    reset = 1'b1;
    drive(VM);
    sample();
    checks++;
    if (obs !== O_IDLE) begin
      errors++;
      $display("FAIL reset_commit: got %b expected %b", obs, O_IDLE);
    end
    advance();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive((c == 0) ? VW : 10'b0);
      sample();
      checks++;
      if (obs !== O_IDLE || obs !== exp_v) begin
        errors++;
        $display("FAIL reset_no_serial cyc%0d: got %b expected %b",
                 c, obs, O_IDLE);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [9:0] v;
    for (int c = 0; c < 500; c++) begin
      v = '0;
      if ($urandom_range(0, 9) == 0) v |= IB;
      if ($urandom_range(0, 9) == 0) v |= DB;
      if ($urandom_range(0, 11) == 0) v |= EX;
      if ($urandom_range(0, 3) == 0) v |= LU;
      if ($urandom_range(0, 11) == 0) v |= BR;
      if ($urandom_range(0, 15) == 0) v |= TR;
      if ($urandom_range(0, 2) == 0) v |= SD;
      if ($urandom_range(0, 1) == 0) v |= VE;
      if ($urandom_range(0, 1) == 0) v |= VM;
      if ($urandom_range(0, 1) == 0) v |= VW;
      reset = ($urandom_range(0, 63) == 0);
      drive(v);
      sample();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random cyc%0d in=%b rst=%b: got %b expected %b",
                 c, v, reset, obs, exp_v);
      end
      advance();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive('0);
    test_reset();
    test_load_use();
    test_lu_branch();
    test_serial_drain();
    test_busy_commit();
    test_trap_drain();
    test_branch_commit();
    test_reset_commit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
